// File: rtl/ex_muldiv_unit.sv
// Execute-stage multiply/divide unit owning HI/LO; all state changes on the falling edge of i_clk.
// Define MULDIV_FAST_MULT_EN to compute MULT/MULTU with a combinational multiplier in two busy cycles.
module ex_muldiv_unit #(
  parameter int NB        = 32,
  parameter int NB_OPCODE = 6,
  parameter int NB_FCODE  = 6,
  parameter int NB_CNT    = 6
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_step,
  input  logic                 i_valid,
  input  logic [NB_OPCODE-1:0] i_instruction_op_code,
  input  logic [NB_FCODE-1:0]  i_instruction_funct_code,
  input  logic [NB-1:0]        i_data_a,
  input  logic [NB-1:0]        i_data_b,
  output logic                 o_busy,
  output logic [NB-1:0]        o_result,
  output logic [NB-1:0]        o_hi,
  output logic [NB-1:0]        o_lo,
  output logic                 o_div_by_zero
);

  localparam logic [NB_FCODE-1:0] FN_MFHI  = NB_FCODE'(6'h10);
  localparam logic [NB_FCODE-1:0] FN_MTHI  = NB_FCODE'(6'h11);
  localparam logic [NB_FCODE-1:0] FN_MFLO  = NB_FCODE'(6'h12);
  localparam logic [NB_FCODE-1:0] FN_MTLO  = NB_FCODE'(6'h13);
  localparam logic [NB_FCODE-1:0] FN_MULT  = NB_FCODE'(6'h18);
  localparam logic [NB_FCODE-1:0] FN_MULTU = NB_FCODE'(6'h19);
  localparam logic [NB_FCODE-1:0] FN_DIV   = NB_FCODE'(6'h1A);
  localparam logic [NB_FCODE-1:0] FN_DIVU  = NB_FCODE'(6'h1B);

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_DONE} state_t;

  state_t              state_reg;
  logic [NB_CNT-1:0]   cnt_reg;
  logic [2*NB-1:0]     acc_reg;
  logic [NB-1:0]       opnd_reg;
  logic [NB-1:0]       hi_reg;
  logic [NB-1:0]       lo_reg;
  logic                dz_reg;
  logic                sign_a_reg;
  logic                sign_b_reg;
  logic                div_op_reg;

  logic                decoded;
  logic                is_mult;
  logic                is_div;
  logic                is_signed;
  logic                start;
  logic [NB-1:0]       abs_a;
  logic [NB-1:0]       abs_b;

  assign decoded   = i_valid && (i_instruction_op_code == '0);
  assign is_mult   = decoded && ((i_instruction_funct_code == FN_MULT) || (i_instruction_funct_code == FN_MULTU));
  assign is_div    = decoded && ((i_instruction_funct_code == FN_DIV) || (i_instruction_funct_code == FN_DIVU));
  assign is_signed = (i_instruction_funct_code == FN_MULT) || (i_instruction_funct_code == FN_DIV);
  assign start     = (state_reg == ST_IDLE) && (is_mult || is_div);
  assign abs_a     = (is_signed && i_data_a[NB-1]) ? -i_data_a : i_data_a;
  assign abs_b     = (is_signed && i_data_b[NB-1]) ? -i_data_b : i_data_b;

  assign o_busy        = start || (state_reg != ST_IDLE);
  assign o_hi          = hi_reg;
  assign o_lo          = lo_reg;
  assign o_div_by_zero = dz_reg;

  always_comb begin
    o_result = '0;
    if (decoded && (i_instruction_funct_code == FN_MFHI)) o_result = hi_reg;
    if (decoded && (i_instruction_funct_code == FN_MFLO)) o_result = lo_reg;
  end

  // Shift-add step: conditionally add the multiplicand into the upper half, then shift right.
  logic [NB:0]     mul_sum;
  logic [2*NB-1:0] mul_next;
  assign mul_sum  = {1'b0, acc_reg[2*NB-1:NB]} + (acc_reg[0] ? {1'b0, opnd_reg} : '0);
  assign mul_next = {mul_sum, acc_reg[NB-1:1]};

  // Restoring step: the shifted remainder needs NB+1 bits; a fitting difference always fits NB bits.
  logic [NB:0]     div_shift;
  logic            div_ge;
  logic [NB-1:0]   div_diff;
  logic [2*NB-1:0] div_next;
  assign div_shift = {acc_reg[2*NB-1:NB], acc_reg[NB-1]};
  assign div_ge    = div_shift >= {1'b0, opnd_reg};
  assign div_diff  = div_shift[NB-1:0] - opnd_reg;
  assign div_next  = div_ge ? {div_diff, acc_reg[NB-2:0], 1'b1} : {acc_reg[2*NB-2:0], 1'b0};

  logic [2*NB-1:0] prod_fix;
  logic [NB-1:0]   quo_fix;
  logic [NB-1:0]   rem_fix;
  assign prod_fix = (sign_a_reg ^ sign_b_reg) ? -acc_reg : acc_reg;
  assign quo_fix  = (sign_a_reg ^ sign_b_reg) ? -acc_reg[NB-1:0] : acc_reg[NB-1:0];
  // With divisor 0 the remainder ends as |a|, so this fix-up restores the raw dividend.
  assign rem_fix  = sign_a_reg ? -acc_reg[2*NB-1:NB] : acc_reg[2*NB-1:NB];

`ifdef MULDIV_FAST_MULT_EN
  logic [2*NB-1:0] fast_prod;
  assign fast_prod = {{NB{1'b0}}, abs_a} * {{NB{1'b0}}, abs_b};
`endif

  always_ff @(negedge i_clk) begin
    if (i_reset) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= '0;
      acc_reg    <= '0;
      opnd_reg   <= '0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      dz_reg     <= 1'b0;
      sign_a_reg <= 1'b0;
      sign_b_reg <= 1'b0;
      div_op_reg <= 1'b0;
    end else if (i_step) begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            cnt_reg    <= '0;
            dz_reg     <= 1'b0;
            sign_a_reg <= is_signed && i_data_a[NB-1];
            sign_b_reg <= is_signed && i_data_b[NB-1];
            div_op_reg <= is_div;
            if (is_div) begin
              opnd_reg  <= abs_b;
              acc_reg   <= {{NB{1'b0}}, abs_a};
              state_reg <= ST_DIV;
            end else begin
`ifdef MULDIV_FAST_MULT_EN
              opnd_reg  <= abs_a;
              acc_reg   <= fast_prod;
              state_reg <= ST_DONE;
`else
              opnd_reg  <= abs_a;
              acc_reg   <= {{NB{1'b0}}, abs_b};
              state_reg <= ST_MUL;
`endif
            end
          end else if (decoded) begin
            if (i_instruction_funct_code == FN_MTHI) hi_reg <= i_data_a;
            if (i_instruction_funct_code == FN_MTLO) lo_reg <= i_data_a;
          end
        end
        ST_MUL: begin
          acc_reg <= mul_next;
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == NB_CNT'(NB - 1)) state_reg <= ST_DONE;
        end
        ST_DIV: begin
          acc_reg <= div_next;
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == NB_CNT'(NB - 1)) state_reg <= ST_DONE;
        end
        default: begin
          if (div_op_reg) begin
            hi_reg <= rem_fix;
            if (opnd_reg == '0) begin
              lo_reg <= '1;
              dz_reg <= 1'b1;
            end else begin
              lo_reg <= quo_fix;
            end
          end else begin
            hi_reg <= prod_fix[2*NB-1:NB];
            lo_reg <= prod_fix[NB-1:0];
          end
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: the driver queues expected HI/LO/flag/busy-length,
// the monitor checks them when busy falls, and checks o_result on MFHI/MFLO and bubbles.
module tb_ex_muldiv_unit;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_step = 1'b1;
  logic        i_valid = 1'b0;
  logic [5:0]  i_instruction_op_code = '0;
  logic [5:0]  i_instruction_funct_code = '0;
  logic [31:0] i_data_a = '0;
  logic [31:0] i_data_b = '0;
  logic        o_busy;
  logic [31:0] o_result;
  logic [31:0] o_hi;
  logic [31:0] o_lo;
  logic        o_div_by_zero;

  ex_muldiv_unit dut (
    .i_clk                    (i_clk),
    .i_reset                  (i_reset),
    .i_step                   (i_step),
    .i_valid                  (i_valid),
    .i_instruction_op_code    (i_instruction_op_code),
    .i_instruction_funct_code (i_instruction_funct_code),
    .i_data_a                 (i_data_a),
    .i_data_b                 (i_data_b),
    .o_busy                   (o_busy),
    .o_result                 (o_result),
    .o_hi                     (o_hi),
    .o_lo                     (o_lo),
    .o_div_by_zero            (o_div_by_zero)
  );

  always #5 i_clk = ~i_clk;

`ifdef MULDIV_FAST_MULT_EN
  localparam int MUL_BUSY = 2;
`else
  localparam int MUL_BUSY = 34;
`endif
  localparam int DIV_BUSY = 34;

  localparam int K_OP = 0, K_READ = 1, K_BUBBLE = 2;

  typedef struct {
    int          kind;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          busy;
    logic [31:0] res;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad = 0;

  function automatic exp_t mk(input int kind, input logic [31:0] hi, input logic [31:0] lo,
                              input logic dz, input int busy, input logic [31:0] res, input string name);
    exp_t e;
    e.kind = kind; e.hi = hi; e.lo = lo; e.dz = dz; e.busy = busy; e.res = res; e.name = name;
    return e;
  endfunction

  // Monitor: samples on the rising edge, half a cycle away from the DUT's falling-edge updates.
  initial begin
    int   busy_cnt;
    logic prev_busy;
    exp_t e;
    busy_cnt  = 0;
    prev_busy = 1'b0;
    forever begin
      @(posedge i_clk);
      if (o_busy) begin
        busy_cnt++;
      end else if (prev_busy) begin
        total++;
        if (sb_q.size() == 0 || sb_q[0].kind != K_OP) begin
          bad++;
          $display("FAIL unexpected_completion: hi=%h lo=%h, required no completion", o_hi, o_lo);
        end else begin
          e = sb_q.pop_front();
          if (o_hi !== e.hi || o_lo !== e.lo || o_div_by_zero !== e.dz || busy_cnt != e.busy) begin
            bad++;
            $display("FAIL %s: hi=%h lo=%h dz=%0b busy=%0d, required hi=%h lo=%h dz=%0b busy=%0d",
                     e.name, o_hi, o_lo, o_div_by_zero, busy_cnt, e.hi, e.lo, e.dz, e.busy);
          end else begin
            $display("txn %s: hi=%h lo=%h dz=%0b busy=%0d ok", e.name, o_hi, o_lo, o_div_by_zero, busy_cnt);
          end
        end
        busy_cnt = 0;
      end
      if (!i_reset && i_valid && i_instruction_op_code == 6'h00 &&
          (i_instruction_funct_code == 6'h10 || i_instruction_funct_code == 6'h12)) begin
        total++;
        if (sb_q.size() == 0 || sb_q[0].kind != K_READ) begin
          bad++;
          $display("FAIL unexpected_read: result=%h, required no read", o_result);
        end else begin
          e = sb_q.pop_front();
          if (o_result !== e.res || o_busy !== 1'b0) begin
            bad++;
            $display("FAIL %s: result=%h busy=%0b, required result=%h busy=0", e.name, o_result, o_busy, e.res);
          end else begin
            $display("txn %s: result=%h ok", e.name, o_result);
          end
        end
      end
      if (!i_reset && !i_valid && i_instruction_funct_code == 6'h18) begin
        total++;
        if (sb_q.size() == 0 || sb_q[0].kind != K_BUBBLE) begin
          bad++;
          $display("FAIL unexpected_bubble: busy=%0b", o_busy);
        end else begin
          e = sb_q.pop_front();
          if (o_busy !== 1'b0 || o_result !== 32'h0) begin
            bad++;
            $display("FAIL %s: busy=%0b result=%h, required busy=0 result=0", e.name, o_busy, o_result);
          end else begin
            $display("txn %s: busy=0 result=0 ok", e.name);
          end
        end
      end
      prev_busy = o_busy;
    end
  end

  task automatic idle_inputs();
    i_valid = 1'b0;
    i_instruction_op_code = 6'h00;
    i_instruction_funct_code = 6'h00;
    i_data_a = '0;
    i_data_b = '0;
  endtask

  task automatic drive(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
    i_valid = 1'b1;
    i_instruction_op_code = 6'h00;
    i_instruction_funct_code = fn;
    i_data_a = a;
    i_data_b = b;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (o_busy && n < 200) begin
      @(negedge i_clk); #1;
      n++;
    end
    if (o_busy) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: busy=%0b after %0d cycles, required 0", name, o_busy, n);
    end
  endtask

  task automatic run_op(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input logic edz,
                        input int ebusy, input string name);
    sb_q.push_back(mk(K_OP, ehi, elo, edz, ebusy, 32'h0, name));
    @(negedge i_clk); #1;
    drive(fn, a, b);
    @(negedge i_clk); #1;
    idle_inputs();
    wait_idle(name);
  endtask

  task automatic one_cycle(input logic [5:0] fn, input logic [31:0] a);
    @(negedge i_clk); #1;
    drive(fn, a, 32'h0);
    @(negedge i_clk); #1;
    idle_inputs();
  endtask

  task automatic read_reg(input logic [5:0] fn, input logic [31:0] eres, input string name);
    sb_q.push_back(mk(K_READ, 32'h0, 32'h0, 1'b0, 0, eres, name));
    one_cycle(fn, 32'h0);
  endtask

  initial begin
    idle_inputs();
    repeat (3) @(negedge i_clk);
    #1;
    i_reset = 1'b0;
    @(posedge i_clk);
    total++;
    if (o_hi !== 32'h0 || o_lo !== 32'h0 || o_div_by_zero !== 1'b0 || o_busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: hi=%h lo=%h dz=%0b busy=%0b, required all 0", o_hi, o_lo, o_div_by_zero, o_busy);
    end else begin
      $display("txn reset_state: ok");
    end

    run_op(6'h19, 32'hFFFF_FFFF, 32'd2,          32'h0000_0001, 32'hFFFF_FFFE, 1'b0, MUL_BUSY, "multu_max_x2");
    run_op(6'h18, 32'hFFFF_FFFD, 32'd7,          32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, MUL_BUSY, "mult_m3_x7");
    run_op(6'h1A, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, DIV_BUSY, "div_m7_by2");
    run_op(6'h1B, 32'd100,       32'd7,          32'h0000_0002, 32'h0000_000E, 1'b0, DIV_BUSY, "divu_100_by7");
    run_op(6'h1B, 32'd5,         32'd0,          32'h0000_0005, 32'hFFFF_FFFF, 1'b1, DIV_BUSY, "divu_5_by0");
    run_op(6'h18, 32'd6,         32'hFFFF_FFFB,  32'hFFFF_FFFF, 32'hFFFF_FFE2, 1'b0, MUL_BUSY, "mult_clears_dz");
    run_op(6'h1A, 32'hFFFF_FFF7, 32'd0,          32'hFFFF_FFF7, 32'hFFFF_FFFF, 1'b1, DIV_BUSY, "div_m9_by0");
    run_op(6'h1A, 32'h8000_0000, 32'hFFFF_FFFF,  32'h0000_0000, 32'h8000_0000, 1'b0, DIV_BUSY, "div_min_by_m1");

    // DIV 1000 / -7 with a 10-cycle step freeze in the middle.
    sb_q.push_back(mk(K_OP, 32'h0000_0006, 32'hFFFF_FF72, 1'b0, DIV_BUSY + 10, 32'h0, "div_stall10"));
    @(negedge i_clk); #1;
    drive(6'h1A, 32'd1000, 32'hFFFF_FFF9);
    @(negedge i_clk); #1;
    idle_inputs();
    repeat (5) @(negedge i_clk);
    #1;
    i_step = 1'b0;
    repeat (10) @(negedge i_clk);
    #1;
    i_step = 1'b1;
    wait_idle("div_stall10");

    // Reset mid-DIV: busy drops on the reset edge and HI/LO clear.
    sb_q.push_back(mk(K_OP, 32'h0, 32'h0, 1'b0, 6, 32'h0, "div_reset_abort"));
    @(negedge i_clk); #1;
    drive(6'h1B, 32'd77, 32'd3);
    @(negedge i_clk); #1;
    idle_inputs();
    repeat (4) @(negedge i_clk);
    #1;
    i_reset = 1'b1;
    @(negedge i_clk); #1;
    i_reset = 1'b0;
    wait_idle("div_reset_abort");

    one_cycle(6'h11, 32'h0000_1234);
    one_cycle(6'h13, 32'h0000_5678);
    read_reg(6'h10, 32'h0000_1234, "mfhi");
    read_reg(6'h12, 32'h0000_5678, "mflo");

    sb_q.push_back(mk(K_BUBBLE, 32'h0, 32'h0, 1'b0, 0, 32'h0, "bubble_mult"));
    @(negedge i_clk); #1;
    i_valid = 1'b0;
    i_instruction_op_code = 6'h00;
    i_instruction_funct_code = 6'h18;
    i_data_a = 32'd9;
    i_data_b = 32'd9;
    @(negedge i_clk); #1;
    idle_inputs();
    read_reg(6'h12, 32'h0000_5678, "mflo_after_bubble");

    repeat (3) @(negedge i_clk);
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: pending=%0d, required 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
